// File: rtl/mac_pkg.sv
// Shared types and helpers for the streaming MAC.
// Provides the counter width helper and a widened add with an optional clamp.
package mac_pkg;

  localparam int ACC_MAX_W = 128;

  typedef logic signed [ACC_MAX_W-1:0] wide_t;

  typedef struct packed {
    wide_t sum;
    logic  ovf;
  } sat_res_t;

  function automatic int cnt_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  // Both addends are sign-extended w-bit values, so the wide sum is exact and
  // overflow is equivalent to the sum leaving the w-bit signed range.
  function automatic sat_res_t sat_add(input wide_t acc, input wide_t p,
                                       input int w, input logic saturate);
    wide_t    full;
    wide_t    hi;
    wide_t    lo;
    sat_res_t res;
    full    = acc + p;
    hi      = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo      = -hi - wide_t'(1);
    res.ovf = (full > hi) || (full < lo);
    res.sum = full;
    if (saturate && res.ovf) begin
      res.sum = (full > hi) ? hi : lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_sat_acc.sv
// Stage-2 accumulator: adds each product, tracks sticky overflow, and
// clears itself on the final product of a vector. Holds when i_en is low.
module mac_sat_acc
  import mac_pkg::*;
#(
  parameter int D_W_ACC  = 64,
  parameter int SATURATE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_en,
  input  logic                      i_last,
  input  logic signed [D_W_ACC-1:0] i_p,
  output logic signed [D_W_ACC-1:0] o_sum,
  output logic                      o_ovf
);

  logic signed [D_W_ACC-1:0] r_acc;
  logic                      r_ovf_acc;
  sat_res_t                  w_res;

  always_comb begin
    w_res = sat_add(wide_t'(r_acc), wide_t'(i_p), D_W_ACC, SATURATE != 0);
    o_sum = w_res.sum[D_W_ACC-1:0];
    o_ovf = r_ovf_acc | w_res.ovf;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc     <= '0;
      r_ovf_acc <= 1'b0;
    end else if (i_en) begin
      if (i_last) begin
        r_acc     <= '0;
        r_ovf_acc <= 1'b0;
      end else begin
        r_acc     <= o_sum;
        r_ovf_acc <= o_ovf;
      end
    end
  end

endmodule

// File: rtl/mac_stream.sv
// Streaming signed dot-product MAC: registered multiply, saturating or wrapping
// accumulate, one result per configurable-length vector with back-pressure.
module mac_stream
  import mac_pkg::*;
#(
  parameter int D_W         = 32,
  parameter int D_W_ACC     = 64,
  parameter int VEC_LEN_MAX = 16,
  parameter int SATURATE    = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [$clog2(VEC_LEN_MAX+1)-1:0]   cfg_len,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic signed [D_W-1:0]              a,
  input  logic signed [D_W-1:0]              b,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic signed [D_W_ACC-1:0]          result,
  output logic                               overflow
);

  localparam int CNT_W = cnt_width(VEC_LEN_MAX);

  typedef enum logic {ST_IDLE, ST_ACCUM} vec_state_e;

  if (D_W_ACC < 2 * D_W || D_W_ACC >= ACC_MAX_W) begin : g_bad_width
    $error("mac_stream: D_W_ACC must be >= 2*D_W and < %0d", ACC_MAX_W);
  end

  vec_state_e                r_state;
  logic [CNT_W-1:0]          r_beat;
  logic [CNT_W-1:0]          r_len;
  logic signed [D_W_ACC-1:0] r_p;
  logic                      r_p_vld;
  logic                      r_p_last;

  logic                      w_adv;
  logic                      w_accept;
  logic                      w_is_last;
  logic                      w_load;
  logic                      w_acc_en;
  logic [CNT_W-1:0]          w_len_cfg;
  logic [CNT_W-1:0]          w_len_eff;
  logic signed [2*D_W-1:0]   w_prod;
  logic signed [D_W_ACC-1:0] w_sum;
  logic                      w_ovf;

  // A pending unaccepted result stalls the whole pipe, including the input.
  always_comb begin
    w_adv     = !m_valid || m_ready;
    w_accept  = s_valid && w_adv;
    w_len_cfg = cfg_len;
    if (cfg_len == '0) begin
      w_len_cfg = CNT_W'(1);
    end else if (cfg_len > CNT_W'(VEC_LEN_MAX)) begin
      w_len_cfg = CNT_W'(VEC_LEN_MAX);
    end
    w_len_eff = (r_state == ST_IDLE) ? w_len_cfg : r_len;
    w_is_last = (r_beat == w_len_eff - CNT_W'(1));
    w_prod    = (2 * D_W)'(a) * (2 * D_W)'(b);
    w_acc_en  = w_adv && r_p_vld;
    w_load    = w_acc_en && r_p_last;
  end

  assign s_ready = w_adv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_beat  <= '0;
      r_len   <= '0;
    end else if (w_accept) begin
      if (r_state == ST_IDLE) begin
        r_len <= w_len_cfg;
      end
      if (w_is_last) begin
        r_beat  <= '0;
        r_state <= ST_IDLE;
      end else begin
        r_beat  <= r_beat + CNT_W'(1);
        r_state <= ST_ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p      <= '0;
      r_p_vld  <= 1'b0;
      r_p_last <= 1'b0;
    end else if (w_adv) begin
      r_p      <= D_W_ACC'(w_prod);
      r_p_vld  <= s_valid;
      r_p_last <= w_is_last;
    end
  end

  mac_sat_acc #(
    .D_W_ACC  (D_W_ACC),
    .SATURATE (SATURATE)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_acc_en),
    .i_last (r_p_last),
    .i_p    (r_p),
    .o_sum  (w_sum),
    .o_ovf  (w_ovf)
  );

  // A final sum loading in the same cycle as acceptance keeps m_valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid  <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
    end else if (w_adv) begin
      m_valid <= w_load;
      if (w_load) begin
        result   <= w_sum;
        overflow <= w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_mac_stream.sv
// Directed self-checking bench for mac_stream: a saturating and a wrapping
// instance share one operand stream so overflow behaviour can be compared.
module tb_mac_stream;

   localparam int D_W         = 8;
   localparam int D_W_ACC     = 16;
   localparam int VEC_LEN_MAX = 16;
   localparam int LEN_W       = $clog2(VEC_LEN_MAX + 1);

   logic                      clk     = 1'b0;
   logic                      rst     = 1'b1;
   logic [LEN_W-1:0]          cfg_len = '0;
   logic                      s_valid = 1'b0;
   logic signed [D_W-1:0]     a       = '0;
   logic signed [D_W-1:0]     b       = '0;
   logic                      m_ready = 1'b1;

   logic                      satReady;
   logic                      satValid;
   logic                      satOvf;
   logic signed [D_W_ACC-1:0] satResult;
   logic                      wrapReady;
   logic                      wrapValid;
   logic                      wrapOvf;
   logic signed [D_W_ACC-1:0] wrapResult;

   int nTests = 0;
   int nFail  = 0;

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   mac_stream #(
      .D_W         (D_W),
      .D_W_ACC     (D_W_ACC),
      .VEC_LEN_MAX (VEC_LEN_MAX),
      .SATURATE    (1)
   ) uSat (
      .clk      (clk),
      .rst      (rst),
      .cfg_len  (cfg_len),
      .s_valid  (s_valid),
      .s_ready  (satReady),
      .a        (a),
      .b        (b),
      .m_valid  (satValid),
      .m_ready  (m_ready),
      .result   (satResult),
      .overflow (satOvf)
   );

   mac_stream #(
      .D_W         (D_W),
      .D_W_ACC     (D_W_ACC),
      .VEC_LEN_MAX (VEC_LEN_MAX),
      .SATURATE    (0)
   ) uWrap (
      .clk      (clk),
      .rst      (rst),
      .cfg_len  (cfg_len),
      .s_valid  (s_valid),
      .s_ready  (wrapReady),
      .a        (a),
      .b        (b),
      .m_valid  (wrapValid),
      .m_ready  (m_ready),
      .result   (wrapResult),
      .overflow (wrapOvf)
   );

   // Drives one cycle of operands, then returns just after the capturing edge.
   task automatic applyStimulus(input logic v, input int av, input int bv);
      s_valid = v;
      a       = D_W'(av);
      b       = D_W'(bv);
      @(posedge clk);
      #1;
   endtask

   // Counts one comparison and reports it if the observed value differs.
   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      nTests++;
      assert (observed === expected) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Linear sequence of directed scenarios.
   initial begin
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset m_valid", 32'(satValid), 0);
      checkOutput("reset result", 32'(satResult), 0);
      checkOutput("reset overflow", 32'(satOvf), 0);
      rst = 1'b1;
      #1;
      checkOutput("reset s_ready", 32'(satReady), 1);

      // 2 + 12 - 30 - 56 = -72
      cfg_len = LEN_W'(4);
      m_ready = 1'b1;
      applyStimulus(1'b1, 1, 2);
      applyStimulus(1'b1, 3, 4);
      applyStimulus(1'b1, -5, 6);
      applyStimulus(1'b1, 7, -8);
      checkOutput("t1 no early result", 32'(satValid), 0);
      applyStimulus(1'b0, 0, 0);
      checkOutput("t1 m_valid", 32'(satValid), 1);
      checkOutput("t1 result", 32'(satResult), -72);
      checkOutput("t1 overflow", 32'(satOvf), 0);
      checkOutput("t1 wrap result", 32'(wrapResult), -72);
      applyStimulus(1'b0, 0, 0);
      checkOutput("t1 m_valid one cycle", 32'(satValid), 0);

      // Back-to-back length-2 vectors: 6+20=26, 1+100=101
      cfg_len = LEN_W'(2);
      applyStimulus(1'b1, 2, 3);
      checkOutput("t2 s_ready b0", 32'(satReady), 1);
      applyStimulus(1'b1, 4, 5);
      checkOutput("t2 m_valid b1", 32'(satValid), 0);
      applyStimulus(1'b1, 1, 1);
      checkOutput("t2 m_valid b2", 32'(satValid), 1);
      checkOutput("t2 result0", 32'(satResult), 26);
      checkOutput("t2 s_ready b2", 32'(satReady), 1);
      applyStimulus(1'b1, 10, 10);
      checkOutput("t2 m_valid b3", 32'(satValid), 0);
      applyStimulus(1'b0, 0, 0);
      checkOutput("t2 m_valid r1", 32'(satValid), 1);
      checkOutput("t2 result1", 32'(satResult), 101);
      applyStimulus(1'b0, 0, 0);
      checkOutput("t2 drained", 32'(satValid), 0);

      // Back-pressure: 9+4=13 held, then 25+36=61 with no lost beat
      m_ready = 1'b0;
      applyStimulus(1'b1, 3, 3);
      applyStimulus(1'b1, 2, 2);
      applyStimulus(1'b1, 5, 5);
      checkOutput("t3 m_valid", 32'(satValid), 1);
      checkOutput("t3 result", 32'(satResult), 13);
      checkOutput("t3 s_ready low", 32'(satReady), 0);
      applyStimulus(1'b1, 6, 6);
      applyStimulus(1'b1, 6, 6);
      checkOutput("t3 held m_valid", 32'(satValid), 1);
      checkOutput("t3 held result", 32'(satResult), 13);
      checkOutput("t3 held s_ready", 32'(satReady), 0);
      m_ready = 1'b1;
      applyStimulus(1'b1, 6, 6);
      checkOutput("t3 released m_valid", 32'(satValid), 0);
      checkOutput("t3 released s_ready", 32'(satReady), 1);
      applyStimulus(1'b0, 0, 0);
      checkOutput("t3 resumed m_valid", 32'(satValid), 1);
      checkOutput("t3 resumed result", 32'(satResult), 61);

      // 4 x 16384 in 16 bits: clamps to 32767, or wraps through -32768 back to 0
      cfg_len = LEN_W'(4);
      repeat (4) applyStimulus(1'b1, -128, -128);
      applyStimulus(1'b0, 0, 0);
      checkOutput("t4 sat m_valid", 32'(satValid), 1);
      checkOutput("t4 sat result", 32'(satResult), 32767);
      checkOutput("t4 sat overflow", 32'(satOvf), 1);
      checkOutput("t4 wrap m_valid", 32'(wrapValid), 1);
      checkOutput("t4 wrap result", 32'(wrapResult), 0);
      checkOutput("t4 wrap overflow", 32'(wrapOvf), 1);
      checkOutput("t4 wrap s_ready", 32'(wrapReady), 1);

      // Length 0 behaves as 1
      cfg_len = LEN_W'(0);
      applyStimulus(1'b1, 9, 9);
      applyStimulus(1'b0, 0, 0);
      checkOutput("t5 len0 m_valid", 32'(satValid), 1);
      checkOutput("t5 len0 result", 32'(satResult), 81);
      checkOutput("t5 len0 overflow cleared", 32'(satOvf), 0);
      checkOutput("t5 len0 wrap overflow cleared", 32'(wrapOvf), 0);

      // Length 20 clamps to 16; mid-vector length change and a bubble are ignored
      cfg_len = LEN_W'(20);
      applyStimulus(1'b1, 1, 1);
      cfg_len = LEN_W'(1);
      repeat (7) applyStimulus(1'b1, 1, 1);
      applyStimulus(1'b0, 0, 0);
      repeat (7) applyStimulus(1'b1, 1, 1);
      checkOutput("t5 clamp no result at 15", 32'(satValid), 0);
      applyStimulus(1'b1, 1, 1);
      checkOutput("t5 clamp no result at 16", 32'(satValid), 0);
      applyStimulus(1'b0, 0, 0);
      checkOutput("t5 clamp m_valid", 32'(satValid), 1);
      checkOutput("t5 clamp result", 32'(satResult), 16);

      // Reset mid-vector discards the partial sum
      cfg_len = LEN_W'(4);
      applyStimulus(1'b1, 7, 7);
      applyStimulus(1'b1, 7, 7);
      rst = 1'b0;
      #2;
      checkOutput("t6 reset m_valid", 32'(satValid), 0);
      checkOutput("t6 reset result", 32'(satResult), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (4) applyStimulus(1'b1, 1, 1);
      applyStimulus(1'b0, 0, 0);
      checkOutput("t6 fresh m_valid", 32'(satValid), 1);
      checkOutput("t6 fresh result", 32'(satResult), 4);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
